// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between the core data port (0) and the loader/debug
// port (1): round-robin grants, bounded locked bursts, registered read return.
module dmem_arbiter #(
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] adr0,
    input  logic [31:0] adr1,
    input  logic [31:0] wd0,
    input  logic [31:0] wd1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rd0,
    output logic [31:0] rd1,
    output logic        MemWrite,
    output logic [31:0] DataAdr,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);
    localparam int unsigned   CW       = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;

    owner_t        owner, owner_nxt;
    logic          last, last_nxt;
    logic [CW-1:0] lock_cnt, lock_cnt_nxt;
    logic          both;
    logic          keep;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= IDLE;
            last     <= 1'b1;
            lock_cnt <= '0;
        end else begin
            owner    <= owner_nxt;
            last     <= last_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    always_comb begin
        both      = req0 & req1;
        keep      = 1'b0;
        owner_nxt = IDLE;
        if (both) begin
            case (owner)
                OWN0:    keep = lock0 && (lock_cnt < LOCK_MAX);
                OWN1:    keep = lock1 && (lock_cnt < LOCK_MAX);
                default: keep = 1'b0;
            endcase
            // Without a valid lock the grant goes to whoever did not own last.
            if (keep) owner_nxt = owner;
            else      owner_nxt = last ? OWN0 : OWN1;
        end else if (req0) begin
            owner_nxt = OWN0;
        end else if (req1) begin
            owner_nxt = OWN1;
        end

        last_nxt = last;
        if (owner_nxt == OWN0) last_nxt = 1'b0;
        if (owner_nxt == OWN1) last_nxt = 1'b1;

        lock_cnt_nxt = '0;
        if (owner_nxt != IDLE && owner_nxt == owner) begin
            if (both && lock_cnt != LOCK_MAX) lock_cnt_nxt = lock_cnt + CW'(1);
            else                              lock_cnt_nxt = lock_cnt;
        end
    end

    always_comb begin
        gnt0      = (owner == OWN0);
        gnt1      = (owner == OWN1);
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        case (owner)
            OWN0: begin
                MemWrite  = we0 & ~reset;
                DataAdr   = adr0;
                WriteData = wd0;
            end
            OWN1: begin
                MemWrite  = we1 & ~reset;
                DataAdr   = adr1;
                WriteData = wd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rd0     <= '0;
            rd1     <= '0;
        end else begin
            rvalid0 <= (owner == OWN0) && !we0;
            rvalid1 <= (owner == OWN1) && !we1;
            if ((owner == OWN0) && !we0) rd0 <= ReadData;
            if ((owner == OWN1) && !we1) rd1 <= ReadData;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: queue-based requesters, a transaction-level ownership
// model and a shadow memory predict grants, memory-side outputs and read returns.
module tb_dmem_arbiter;
    localparam int unsigned MAX_LOCK = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0, req1, lock0, lock1, we0, we1;
    logic [31:0] adr0, adr1, wd0, wd1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rd0, rd1;
    logic        MemWrite;
    logic [31:0] DataAdr, WriteData;
    logic [31:0] ReadData = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .adr0(adr0), .adr1(adr1), .wd0(wd0), .wd1(wd1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rd0(rd0), .rd1(rd1),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .ReadData(ReadData)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
    } txn_t;

    txn_t        q0[$];
    txn_t        q1[$];
    logic        lk0 = 1'b0;
    logic        lk1 = 1'b0;
    logic [31:0] envmem [logic [31:0]];
    logic [31:0] shadow [logic [31:0]];

    // Model: owner -1 = nobody, 0/1 = requester; last and burst count per the rules.
    int          m_owner = -1;
    int          m_last  = 1;
    int          m_cnt   = 0;
    logic        m_rv0 = 1'b0, m_rv1 = 1'b0;
    logic [31:0] m_rd0 = '0, m_rd1 = '0;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] rdenv(logic [31:0] a);
        return envmem.exists(a) ? envmem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] rdsh(logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : 32'h0;
    endfunction

    function automatic txn_t mk(logic we, logic [31:0] adr, logic [31:0] wd);
        txn_t t;
        t.we = we; t.adr = adr; t.wd = wd;
        return t;
    endfunction

    function automatic int obs_owner();
        if (gnt0 && gnt1) return -2;
        if (gnt0) return 0;
        if (gnt1) return 1;
        return -1;
    endfunction

    // Requester protocol: operands of the head are shown until granted; during a
    // grant cycle req means "one more after this one".
    task automatic drive_inputs();
        txn_t h0, h1;
        h0 = (q0.size() > 0) ? q0[0] : mk(1'b0, '0, '0);
        h1 = (q1.size() > 0) ? q1[0] : mk(1'b0, '0, '0);
        req0  = q0.size() > ((m_owner == 0) ? 1 : 0);
        req1  = q1.size() > ((m_owner == 1) ? 1 : 0);
        lock0 = lk0 & req0;
        lock1 = lk1 & req1;
        we0 = h0.we; adr0 = h0.adr; wd0 = h0.wd;
        we1 = h1.we; adr1 = h1.adr; wd1 = h1.wd;
    endtask

    task automatic cycle();
        int          n_owner, n_last, n_cnt;
        logic        nrv0, nrv1, mw;
        logic [31:0] nrd0, nrd1, da, wdat;
        txn_t        t;
        @(negedge clk);
        ReadData = rdenv(DataAdr);
        mw = MemWrite; da = DataAdr; wdat = WriteData;
        nrv0 = 1'b0; nrv1 = 1'b0; nrd0 = m_rd0; nrd1 = m_rd1;
        if (reset) begin
            n_owner = -1; n_last = 1; n_cnt = 0; nrd0 = '0; nrd1 = '0;
        end else begin
            if (m_owner >= 0) begin
                t = (m_owner == 0) ? q0[0] : q1[0];
                if (t.we) shadow[t.adr] = t.wd;
                else if (m_owner == 0) begin nrv0 = 1'b1; nrd0 = rdsh(t.adr); end
                else begin nrv1 = 1'b1; nrd1 = rdsh(t.adr); end
            end
            if (!req0 && !req1)      n_owner = -1;
            else if (!req1)          n_owner = 0;
            else if (!req0)          n_owner = 1;
            else if (m_owner >= 0 && ((m_owner == 0) ? lock0 : lock1) && m_cnt < int'(MAX_LOCK))
                                     n_owner = m_owner;
            else                     n_owner = 1 - m_last;
            n_last = (n_owner < 0) ? m_last : n_owner;
            if (n_owner < 0 || n_owner != m_owner) n_cnt = 0;
            else if (req0 && req1)                 n_cnt = (m_cnt < int'(MAX_LOCK)) ? m_cnt + 1 : m_cnt;
            else                                   n_cnt = m_cnt;
        end
        @(posedge clk);
        if (mw) envmem[da] = wdat;
        #1;
        if (m_owner == 0 && q0.size() > 0) void'(q0.pop_front());
        if (m_owner == 1 && q1.size() > 0) void'(q1.pop_front());
        m_owner = n_owner; m_last = n_last; m_cnt = n_cnt;
        m_rv0 = nrv0; m_rv1 = nrv1; m_rd0 = nrd0; m_rd1 = nrd1;
        drive_inputs();
        #1;
    endtask

    task automatic do_reset();
        q0.delete(); q1.delete(); lk0 = 1'b0; lk1 = 1'b0;
        reset = 1'b1;
        drive_inputs();
        cycle(); cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_inputs();
        cycle(); cycle();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, MemWrite} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {gnt0, gnt1, rvalid0, rvalid1, MemWrite});
        checks++;
        if (rd0 !== 32'h0 || rd1 !== 32'h0)
            begin errors++; $display("FAIL reset_rd: got %h/%h want 0/0", rd0, rd1); end
        checks++;
        if (DataAdr !== 32'h0 || WriteData !== 32'h0)
            begin errors++; $display("FAIL reset_mem: got %h/%h want 0/0", DataAdr, WriteData); end
        if ({gnt0, gnt1, rvalid0, rvalid1, MemWrite} !== 5'b0) errors++;
        reset = 1'b0;
        drive_inputs();
    endtask

    task automatic test_single_read();
        envmem[32'h10] = 32'hDEADBEEF;
        shadow[32'h10] = 32'hDEADBEEF;
        q0.push_back(mk(1'b0, 32'h10, 32'h0));
        drive_inputs();
        cycle();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0)
            begin errors++; $display("FAIL single_read_gnt: got %b%b want 10", gnt0, gnt1); end
        checks++;
        if (DataAdr !== 32'h10 || MemWrite !== 1'b0)
            begin errors++; $display("FAIL single_read_bus: got adr=%h we=%b want 10/0", DataAdr, MemWrite); end
        cycle();
        checks++;
        if (rvalid0 !== 1'b1 || rd0 !== 32'hDEADBEEF)
            begin errors++; $display("FAIL single_read_data: got v=%b rd=%h want 1/deadbeef", rvalid0, rd0); end
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || rvalid1 !== 1'b0)
            begin errors++; $display("FAIL single_read_idle: got %b%b%b want 000", gnt0, gnt1, rvalid1); end
        cycle();
        checks++;
        if (rvalid0 !== 1'b0 || rd0 !== 32'hDEADBEEF)
            begin errors++; $display("FAIL single_read_hold: got v=%b rd=%h want 0/deadbeef", rvalid0, rd0); end
    endtask

    task automatic test_contention();
        int          exp_own [7] = '{0, 1, 0, 1, 0, 1, -1};
        logic [31:0] exp_adr [6] = '{32'h20, 32'h30, 32'h24, 32'h34, 32'h28, 32'h38};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            q0.push_back(mk(1'b1, 32'h20 + 32'(4 * k), 32'hA000_0000 + 32'(k)));
            q1.push_back(mk(1'b1, 32'h30 + 32'(4 * k), 32'hB000_0000 + 32'(k)));
        end
        drive_inputs();
        for (int i = 0; i < 7; i++) begin
            cycle();
            checks++;
            if (obs_owner() !== exp_own[i])
                begin errors++; $display("FAIL contention_order[%0d]: got %0d want %0d", i, obs_owner(), exp_own[i]); end
            if (i < 6) begin
                checks++;
                if (MemWrite !== 1'b1 || DataAdr !== exp_adr[i])
                    begin errors++; $display("FAIL contention_bus[%0d]: got we=%b adr=%h want 1/%h", i, MemWrite, DataAdr, exp_adr[i]); end
            end
        end
    endtask

    task automatic test_locked_burst();
        int exp_own [10] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, -1};
        do_reset();
        lk1 = 1'b1;
        for (int k = 0; k < 8; k++)
            q1.push_back(mk(1'b1, 32'h100 + 32'(4 * k), 32'h1000 + 32'(k)));
        drive_inputs();
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if (obs_owner() !== exp_own[i])
                begin errors++; $display("FAIL lock_order[%0d]: got %0d want %0d", i, obs_owner(), exp_own[i]); end
            if (i == 0) begin
                q0.push_back(mk(1'b1, 32'h300, 32'h0C0FFEE0));
                drive_inputs();
            end
        end
        lk1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rdenv(32'h100 + 32'(4 * k)) !== 32'h1000 + 32'(k))
                begin errors++; $display("FAIL lock_mem[%0d]: got %h want %h", k, rdenv(32'h100 + 32'(4 * k)), 32'h1000 + 32'(k)); end
        end
        checks++;
        if (rdenv(32'h300) !== 32'h0C0FFEE0)
            begin errors++; $display("FAIL lock_mem_r0: got %h want 0c0ffee0", rdenv(32'h300)); end
    endtask

    task automatic test_streaming();
        for (int k = 0; k < 5; k++)
            q1.push_back(mk(1'b1, 32'h200 + 32'(4 * k), 32'h2000_0000 + 32'(k)));
        drive_inputs();
        for (int i = 0; i < 6; i++) begin
            cycle();
            checks++;
            if (gnt1 !== (i < 5) || gnt0 !== 1'b0)
                begin errors++; $display("FAIL stream_gnt[%0d]: got %b%b want 0%b", i, gnt0, gnt1, i < 5); end
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rdenv(32'h200 + 32'(4 * k)) !== 32'h2000_0000 + 32'(k))
                begin errors++; $display("FAIL stream_mem[%0d]: got %h want %h", k, rdenv(32'h200 + 32'(4 * k)), 32'h2000_0000 + 32'(k)); end
        end
    endtask

    task automatic test_random();
        txn_t        h;
        logic        e_mw;
        logic [31:0] e_da, e_wd;
        do_reset();
        for (int i = 0; i < 360; i++) begin
            cycle();
            checks++;
            if (gnt0 !== (m_owner == 0) || gnt1 !== (m_owner == 1))
                begin errors++; $display("FAIL rand_gnt[%0d]: got %b%b want owner %0d", i, gnt0, gnt1, m_owner); end
            checks++;
            if (rvalid0 !== m_rv0 || rd0 !== m_rd0)
                begin errors++; $display("FAIL rand_rd0[%0d]: got %b/%h want %b/%h", i, rvalid0, rd0, m_rv0, m_rd0); end
            checks++;
            if (rvalid1 !== m_rv1 || rd1 !== m_rd1)
                begin errors++; $display("FAIL rand_rd1[%0d]: got %b/%h want %b/%h", i, rvalid1, rd1, m_rv1, m_rd1); end
            h = (m_owner == 0) ? q0[0] : (m_owner == 1) ? q1[0] : mk(1'b0, '0, '0);
            e_mw = h.we; e_da = h.adr; e_wd = h.wd;
            checks++;
            if (MemWrite !== e_mw || DataAdr !== e_da || WriteData !== e_wd)
                begin errors++; $display("FAIL rand_bus[%0d]: got %b/%h/%h want %b/%h/%h", i, MemWrite, DataAdr, WriteData, e_mw, e_da, e_wd); end
            if (i < 300) begin
                if (q0.size() < 4 && $urandom_range(0, 2) == 0)
                    q0.push_back(mk(1'(($urandom_range(0, 1))), 32'(4 * $urandom_range(0, 15)), $urandom));
                if (q1.size() < 4 && $urandom_range(0, 2) == 0)
                    q1.push_back(mk(1'(($urandom_range(0, 1))), 32'(4 * $urandom_range(0, 15)), $urandom));
                lk0 = 1'($urandom_range(0, 1));
                lk1 = 1'($urandom_range(0, 1));
            end else begin
                lk0 = 1'b0; lk1 = 1'b0;
            end
            drive_inputs();
        end
        for (int a = 0; a < 16; a++) begin
            checks++;
            if (rdenv(32'(4 * a)) !== rdsh(32'(4 * a)))
                begin errors++; $display("FAIL rand_mem[%0d]: got %h want %h", a, rdenv(32'(4 * a)), rdsh(32'(4 * a))); end
        end
    endtask

    task automatic test_reset_mid_write();
        envmem[32'h40] = 32'hA5A5A5A5;
        shadow[32'h40] = 32'hA5A5A5A5;
        q0.push_back(mk(1'b1, 32'h40, 32'h12345678));
        drive_inputs();
        cycle();
        checks++;
        if (gnt0 !== 1'b1)
            begin errors++; $display("FAIL rst_write_gnt: got %b want 1", gnt0); end
        reset = 1'b1;
        #1;
        checks++;
        if (MemWrite !== 1'b0)
            begin errors++; $display("FAIL rst_write_we: got %b want 0", MemWrite); end
        cycle();
        checks++;
        if (rdenv(32'h40) !== 32'hA5A5A5A5)
            begin errors++; $display("FAIL rst_write_mem: got %h want a5a5a5a5", rdenv(32'h40)); end
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, MemWrite} !== 5'b0 || rd0 !== 32'h0 || rd1 !== 32'h0 ||
            DataAdr !== 32'h0 || WriteData !== 32'h0)
            begin errors++; $display("FAIL rst_write_outs: got %b%b%b%b%b rd=%h/%h bus=%h/%h want all 0",
                gnt0, gnt1, rvalid0, rvalid1, MemWrite, rd0, rd1, DataAdr, WriteData); end
        reset = 1'b0;
        q0.push_back(mk(1'b0, 32'h10, 32'h0));
        q1.push_back(mk(1'b0, 32'h14, 32'h0));
        drive_inputs();
        cycle();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0)
            begin errors++; $display("FAIL rst_first_tie: got %b%b want 10", gnt0, gnt1); end
        cycle(); cycle(); cycle();
    endtask

    initial begin
        drive_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_locked_burst();
        test_streaming();
        test_random();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
